// File: rtl/ps2_keystroke_gen_pkg.sv
// ps2_pkg: shared PS/2 constants, event entry type, FSM states and odd-parity helper for ps2_keystroke_gen
package ps2_pkg;
  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam int         PS2_FRAME_BITS   = 11;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;
  typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} ps2_state_t;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_keystroke_gen_if.sv
// ps2_keystroke_gen_if: key event valid/ready port (key_valid, key_ready, key_code, key_ext, key_release); master offers events, slave accepts
interface ps2_keystroke_gen_if;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  modport master (output key_valid, key_code, key_ext, key_release, input key_ready);
  modport slave  (input key_valid, key_code, key_ext, key_release, output key_ready);
endinterface

// File: rtl/ps2_cmd_fifo.sv
// ps2_cmd_fifo: show-ahead event FIFO; ports clk, rst_n (async low), push/din, pop/dout, level (entry count), ready (not full)
module ps2_cmd_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  ps2_entry_t             din,
  input  logic                   pop,
  output ps2_entry_t             dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ready
);
  localparam int AW = $clog2(DEPTH);
  ps2_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   level_q, level_d;
  always_comb begin
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
  assign dout  = mem_q[rd_q];
  assign level = level_q;
  // depth is a power of two, so the MSB of the count alone flags full
  assign ready = !level_q[AW];
endmodule

// File: rtl/ps2_keystroke_gen.sv
// ps2_keystroke_gen: PS/2 device keystroke generator; ports CLOCK_50, resetn (async low), key (event slave port), PS2_CLK/PS2_DAT, busy, fifo_level
module ps2_keystroke_gen
  import ps2_pkg::*;
#(
  parameter int HALF_CYCLES = 2000,
  parameter int FIFO_DEPTH  = 8,
  parameter int GAP_SLOTS   = 2
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  ps2_keystroke_gen_if.slave          key,
  output logic                        PS2_CLK,
  output logic                        PS2_DAT,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int CW = $clog2(HALF_CYCLES);
  localparam int GW = $clog2(2 * GAP_SLOTS);
  ps2_state_t                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [3:0]                idx_q, idx_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic [7:0]                byte_q, byte_d, code_q, code_d, src_code;
  logic [2:0]                rem_q, rem_d, src_rem;
  logic                      clk_q, clk_d, dat_q, dat_d;
  logic                      pop, load, half_done;
  logic [PS2_FRAME_BITS-1:0] frame;
  ps2_entry_t                wr_entry, rd_entry;
  assign wr_entry = {key.key_ext, key.key_release, key.key_code};
  ps2_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .push  (key.key_valid && key.key_ready),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (rd_entry),
    .level (fifo_level),
    .ready (key.key_ready)
  );
  // rem = {E0 pending, F0 pending, code pending}; IDLE takes it fresh from the FIFO head
  always_comb begin
    src_rem   = state_q == IDLE ? {rd_entry.ext, rd_entry.brk, 1'b1} : rem_q;
    src_code  = state_q == IDLE ? rd_entry.code : code_q;
    half_done = cnt_q == '0;
    state_d   = state_q;
    cnt_d     = cnt_q - 1'b1;
    idx_d     = idx_q;
    gap_d     = gap_q;
    byte_d    = byte_q;
    code_d    = code_q;
    rem_d     = rem_q;
    pop       = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = CW'(HALF_CYCLES - 1);
        pop   = fifo_level != '0;
        load  = pop;
      end
      BIT_HI: if (half_done) begin
        cnt_d   = CW'(HALF_CYCLES - 1);
        state_d = BIT_LO;
      end
      BIT_LO: if (half_done) begin
        cnt_d   = CW'(HALF_CYCLES - 1);
        state_d = idx_q < 4'(PS2_FRAME_BITS - 1) ? BIT_HI : GAP;
        idx_d   = idx_q + 1'b1;
        gap_d   = '0;
      end
      default: if (half_done) begin
        cnt_d = CW'(HALF_CYCLES - 1);
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(2 * GAP_SLOTS - 1)) begin
          state_d = IDLE;
          load    = rem_q != '0;
        end
      end
    endcase
    if (load) begin
      state_d = BIT_HI;
      idx_d   = '0;
      code_d  = src_code;
      byte_d  = src_rem[2] ? PS2_EXT_PREFIX : src_rem[1] ? PS2_BREAK_PREFIX : src_code;
      rem_d   = src_rem[2] ? {1'b0, src_rem[1:0]} : {2'b00, src_rem[1]};
    end
    frame = {1'b1, odd_parity(byte_q), byte_q, 1'b0};
    clk_d = state_q != BIT_LO;
    dat_d = (state_q == BIT_HI || state_q == BIT_LO) ? frame[idx_q] : 1'b1;
  end
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      byte_q  <= '0;
      code_q  <= '0;
      rem_q   <= '0;
      clk_q   <= 1'b1;
      dat_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      byte_q  <= byte_d;
      code_q  <= code_d;
      rem_q   <= rem_d;
      clk_q   <= clk_d;
      dat_q   <= dat_d;
    end
  assign PS2_CLK = clk_q;
  assign PS2_DAT = dat_q;
  assign busy    = state_q != IDLE || fifo_level != '0;
endmodule

// File: tb/tb_ps2_keystroke_gen.sv
// tb_ps2_keystroke_gen: directed self-checking bench for ps2_keystroke_gen (HALF_CYCLES=4, GAP_SLOTS=2, FIFO_DEPTH=4)
module tb_ps2_keystroke_gen;
  localparam int HC = 4, GS = 2, FD = 4;
  logic CLOCK_50 = 1'b0;
  logic resetn = 1'b0;
  logic PS2_CLK, PS2_DAT, busy;
  logic [2:0] fifo_level;
  ps2_keystroke_gen_if kif();
  ps2_keystroke_gen #(.HALF_CYCLES(HC), .FIFO_DEPTH(FD), .GAP_SLOTS(GS)) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .key        (kif),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .busy       (busy),
    .fifo_level (fifo_level)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;
  int checks = 0, fails = 0;
  int tbad = 0, pulses = 0, bcnt = 0, lowcnt = 0, hicnt = 0;
  logic prev_clk = 1'b1, prev_dat = 1'b1, in_frame = 1'b0;
  logic [10:0] shreg = '0;
  logic [10:0] frames_q[$];
  int starts_q[$];
  // line monitor: decodes frames at PS2_CLK falls and measures pulse widths, sampled mid-cycle
  always @(negedge CLOCK_50) begin
    if (!resetn) begin
      bcnt = 0; in_frame = 1'b0; prev_clk = 1'b1; prev_dat = 1'b1; lowcnt = 0; hicnt = 0;
    end else begin
      if (!PS2_CLK && PS2_DAT !== prev_dat) tbad++;
      if (!in_frame && prev_dat && !PS2_DAT && PS2_CLK) begin
        in_frame = 1'b1; bcnt = 0; hicnt = 0; starts_q.push_back(cyc);
      end
      if (!prev_clk && PS2_CLK) begin
        if (lowcnt != HC) tbad++;
        pulses++; lowcnt = 0;
      end
      if (prev_clk && !PS2_CLK && in_frame) begin
        if (hicnt != HC) tbad++;
        hicnt = 0; shreg[bcnt] = PS2_DAT; bcnt++;
        if (bcnt == 11) begin frames_q.push_back(shreg); in_frame = 1'b0; end
      end
      if (PS2_CLK) begin if (in_frame) hicnt++; end
      else lowcnt++;
      prev_clk = PS2_CLK; prev_dat = PS2_DAT;
    end
  end
  task automatic push_event(input logic [7:0] c, input logic e, input logic r, output int n);
    kif.key_code = c; kif.key_ext = e; kif.key_release = r; kif.key_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    n = cyc; kif.key_valid = 1'b0;
  endtask
  task automatic wait_idle(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge CLOCK_50); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask
  task automatic test_reset();
    kif.key_valid = 1'b0; kif.key_code = '0; kif.key_ext = 1'b0; kif.key_release = 1'b0;
    resetn = 1'b0;
    repeat (3) @(posedge CLOCK_50); #1;
    checks++; if ({PS2_CLK, PS2_DAT} !== 2'b11) begin fails++; $display("FAIL reset_lines: got %b expected 11", {PS2_CLK, PS2_DAT}); end
    checks++; if ({kif.key_ready, busy} !== 2'b10) begin fails++; $display("FAIL reset_ready_busy: got %b expected 10", {kif.key_ready, busy}); end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    resetn = 1'b1;
    repeat (3) @(posedge CLOCK_50); #1;
    checks++; if ({PS2_CLK, PS2_DAT, kif.key_ready, busy} !== 4'b1110) begin fails++; $display("FAIL post_reset_idle: got %b expected 1110", {PS2_CLK, PS2_DAT, kif.key_ready, busy}); end
  endtask
  task automatic test_make_code();
    int n, cnt;
    frames_q.delete(); starts_q.delete();
    push_event(8'h1D, 1'b0, 1'b0, n);
    checks++; if (busy !== 1'b1 || fifo_level !== 3'd1) begin fails++; $display("FAIL make_busy_on_push: got busy=%b level=%0d expected busy=1 level=1", busy, fifo_level); end
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLOCK_50); #1;
      if (busy) cnt++; else break;
    end
    checks++; if (cnt != 104) begin fails++; $display("FAIL make_busy_len: got %0d expected 104", cnt); end
    checks++; if (frames_q.size() != 1) begin fails++; $display("FAIL make_frame_count: got %0d expected 1", frames_q.size()); end
    checks++; if (frames_q[0] !== 11'h63A) begin fails++; $display("FAIL make_frame: got %h expected 63a", frames_q[0]); end
    checks++; if (starts_q[0] != n + 2) begin fails++; $display("FAIL make_latency: got %0d expected %0d", starts_q[0], n + 2); end
  endtask
  task automatic test_ext_break();
    int n; logic ok;
    logic [10:0] exp_f [3] = '{11'h5C0, 11'h7E0, 11'h4D6};
    frames_q.delete(); starts_q.delete();
    push_event(8'h6B, 1'b1, 1'b1, n);
    wait_idle(1000, ok);
    checks++; if (!ok || frames_q.size() != 3) begin fails++; $display("FAIL ext_frame_count: got %0d idle=%b expected 3 idle=1", frames_q.size(), ok); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (frames_q[i] !== exp_f[i]) begin fails++; $display("FAIL ext_frame%0d: got %h expected %h", i, frames_q[i], exp_f[i]); end
    end
    checks++; if (starts_q[0] != n + 2) begin fails++; $display("FAIL ext_latency: got %0d expected %0d", starts_q[0], n + 2); end
    checks++; if (starts_q[1] - starts_q[0] != 104 || starts_q[2] - starts_q[1] != 104) begin fails++; $display("FAIL ext_spacing: got %0d,%0d expected 104,104", starts_q[1] - starts_q[0], starts_q[2] - starts_q[1]); end
  endtask
  task automatic test_parity();
    int n0, n1; logic ok;
    frames_q.delete(); starts_q.delete();
    push_event(8'h00, 1'b0, 1'b0, n0);
    push_event(8'hFF, 1'b0, 1'b0, n1);
    wait_idle(1000, ok);
    checks++; if (!ok || frames_q.size() != 2) begin fails++; $display("FAIL parity_frame_count: got %0d idle=%b expected 2 idle=1", frames_q.size(), ok); end
    checks++; if (frames_q[0] !== 11'h600) begin fails++; $display("FAIL parity_00: got %h expected 600", frames_q[0]); end
    checks++; if (frames_q[1] !== 11'h7FE) begin fails++; $display("FAIL parity_ff: got %h expected 7fe", frames_q[1]); end
    checks++; if (starts_q[0] != n0 + 2) begin fails++; $display("FAIL parity_latency: got %0d expected %0d", starts_q[0], n0 + 2); end
    checks++; if (starts_q[1] - starts_q[0] != 105) begin fails++; $display("FAIL parity_b2b_spacing: got %0d expected 105", starts_q[1] - starts_q[0]); end
  endtask
  task automatic test_backpressure();
    logic [7:0] codes [6] = '{8'h15, 8'h1C, 8'h24, 8'h2D, 8'h3A, 8'h43};
    logic       pars  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic saw_full, ok;
    int rdy_bad, t;
    frames_q.delete(); starts_q.delete();
    saw_full = 1'b0; rdy_bad = 0;
    kif.key_ext = 1'b0; kif.key_release = 1'b0; kif.key_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      kif.key_code = codes[i];
      t = 0;
      while (!kif.key_ready && t < 1000) begin
        if (fifo_level == 3'd4) saw_full = 1'b1;
        @(posedge CLOCK_50); #1; t++;
        if (kif.key_ready !== (fifo_level < 3'(FD))) rdy_bad++;
      end
      @(posedge CLOCK_50); #1;
      if (fifo_level == 3'd4) saw_full = 1'b1;
      if (kif.key_ready !== (fifo_level < 3'(FD)) || fifo_level > 3'd4) rdy_bad++;
    end
    kif.key_valid = 1'b0;
    checks++; if (saw_full !== 1'b1) begin fails++; $display("FAIL bp_full_reached: got %b expected 1", saw_full); end
    checks++; if (rdy_bad != 0) begin fails++; $display("FAIL bp_ready_vs_level: got %0d bad cycles expected 0", rdy_bad); end
    wait_idle(2000, ok);
    checks++; if (!ok || frames_q.size() != 6) begin fails++; $display("FAIL bp_frame_count: got %0d idle=%b expected 6 idle=1", frames_q.size(), ok); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (frames_q[i] !== {1'b1, pars[i], codes[i], 1'b0}) begin fails++; $display("FAIL bp_frame%0d: got %h expected %h", i, frames_q[i], {1'b1, pars[i], codes[i], 1'b0}); end
    end
  endtask
  task automatic test_reset_mid_frame();
    int n, t, at, idle_bad; logic ok;
    frames_q.delete(); starts_q.delete();
    push_event(8'h11, 1'b0, 1'b0, n);
    push_event(8'h22, 1'b0, 1'b0, n);
    push_event(8'h33, 1'b0, 1'b0, n);
    push_event(8'h44, 1'b0, 1'b0, n);
    t = 0;
    while (!(in_frame && bcnt == 5) && t < 500) begin @(negedge CLOCK_50); #1; t++; end
    checks++; if ({PS2_CLK, PS2_DAT} !== 2'b00 || fifo_level !== 3'd3) begin fails++; $display("FAIL rst_pre_state: got clk/dat=%b level=%0d expected 00 level=3", {PS2_CLK, PS2_DAT}, fifo_level); end
    at = cyc;
    resetn = 1'b0;
    #1;
    checks++; if ({PS2_CLK, PS2_DAT} !== 2'b11 || cyc != at) begin fails++; $display("FAIL rst_async_lines: got %b cyc+%0d expected 11 cyc+0", {PS2_CLK, PS2_DAT}, cyc - at); end
    checks++; if (fifo_level !== 3'd0 || busy !== 1'b0 || kif.key_ready !== 1'b1) begin fails++; $display("FAIL rst_async_state: got level=%0d busy=%b ready=%b expected 0 0 1", fifo_level, busy, kif.key_ready); end
    repeat (2) @(posedge CLOCK_50); #1;
    resetn = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLOCK_50); #1;
      if ({PS2_CLK, PS2_DAT, busy} !== 3'b110) idle_bad++;
    end
    checks++; if (idle_bad != 0 || frames_q.size() != 0) begin fails++; $display("FAIL rst_stays_idle: got %0d active cycles %0d frames expected 0 0", idle_bad, frames_q.size()); end
    push_event(8'h1D, 1'b0, 1'b0, n);
    wait_idle(500, ok);
    checks++; if (!ok || frames_q.size() != 1 || frames_q[0] !== 11'h63A) begin fails++; $display("FAIL rst_recovery: got %0d frames first=%h expected 1 frame 63a", frames_q.size(), frames_q[0]); end
  endtask
  task automatic test_timing();
    checks++; if (tbad != 0) begin fails++; $display("FAIL timing_violations: got %0d expected 0", tbad); end
    checks++; if (pulses < 143) begin fails++; $display("FAIL timing_pulse_count: got %0d expected at least 143", pulses); end
  endtask
  initial begin
    test_reset();
    test_make_code();
    test_ext_break();
    test_parity();
    test_backpressure();
    test_reset_mid_frame();
    test_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/ps2_keystroke_gen.md
# ps2_keystroke_gen

- Parametrised PS/2 device-side keystroke generator.
- Accepts key events (scan code plus extended/release flags) through a valid/ready port and buffers them in a FIFO.
- Expands each event into the PS/2 byte sequence `[E0] [F0] code` and serialises it as 11-bit PS/2 frames on `PS2_CLK`/`PS2_DAT`, with configurable bit rate and inter-frame gap.
- Drives the keyboard input of the tetris top level in simulation and on-board self-test, replacing hand-written idle/stimulus processes.

## Interface

Parameters:
- `HALF_CYCLES`, 2000 — `CLOCK_50` cycles per PS/2 clock half-period (12.5 kHz at 50 MHz); minimum 2.
- `FIFO_DEPTH`, 8 — number of event entries; power of two, ≥ 2.
- `GAP_SLOTS`, 2 — idle bit slots (2·`HALF_CYCLES` each) between consecutive frames; ≥ 1.

Ports:
- `CLOCK_50` in 1 — single clock, rising edge.
- `resetn` in 1 — asynchronous, active-low reset.
- `key_valid` in 1 — event offered.
- `key_ready` out 1 — FIFO not full; transfer on `key_valid && key_ready`.
- `key_code` in 8 — scan code.
- `key_ext` in 1 — prefix the sequence with `E0`.
- `key_release` in 1 — prefix the code with `F0` (break).
- `PS2_CLK` out 1 — PS/2 clock; idle 1.
- `PS2_DAT` out 1 — PS/2 data; idle 1.
- `busy` out 1 — FIFO non-empty or FSM not in IDLE.
- `fifo_level` out $clog2(FIFO_DEPTH)+1 — current entry count.

## Operation

- **FIFO entry:** 10 bits `{ext, release, code}`.
  - Push on handshake.
  - Pop only from IDLE.
  - Simultaneous push and pop when full is impossible: `key_ready` = (level < `FIFO_DEPTH`), combinational from registered level.
  - Simultaneous push and pop otherwise leaves `fifo_level` unchanged.
- **Byte sequencer:** per event, emits bytes in order `E0` (if ext), `F0` (if release), `code`. Emits 1 to 3 frames.
- **Frame format:** start 0, data bits 0..7 LSB first, odd parity (data ones + parity = odd), stop 1.
- **Bit slot:**
  - First half-period: `PS2_CLK`=1, with `PS2_DAT` updated at slot start.
  - Second half-period: `PS2_CLK`=0.
  - Data is stable across every `PS2_CLK` falling edge.
- **FSM states:**
  - IDLE: outputs 1. If FIFO non-empty, pop, load the first byte → BIT_HI.
  - BIT_HI: `PS2_CLK`=1 for `HALF_CYCLES` → BIT_LO.
  - BIT_LO: `PS2_CLK`=0 for `HALF_CYCLES`. If bit index < 10: index+1 → BIT_HI. Else → GAP.
  - GAP: both lines 1 for `GAP_SLOTS`·2·`HALF_CYCLES` cycles. If further bytes remain in the event, load the next → BIT_HI. Else → IDLE.
- Half-period counter width is $clog2(`HALF_CYCLES`); it reloads on every state entry.
- **Reset value of every output:**
  - `PS2_CLK`=1, `PS2_DAT`=1.
  - `key_ready`=1, `busy`=0, `fifo_level`=0.
  - FIFO emptied, FSM in IDLE.
- **Reset mid-frame:** lines return to 1 asynchronously. The partial frame is abandoned and is not resumed.
- `PS2_CLK` and `PS2_DAT` are registered outputs, glitch-free.

## Timing

- **Latency:** event accepted at edge N; start bit (`PS2_DAT` 1→0) appears after edge N+2 when the FIFO was empty and the FSM was in IDLE.
- The first `PS2_CLK` fall occurs `HALF_CYCLES` cycles after the start bit.
- **Frame length:** 22·`HALF_CYCLES` cycles.
- **Event duration:** frames·(22 + 2·`GAP_SLOTS`)·`HALF_CYCLES`.
- **Back-to-back events:** the next event's start bit follows the previous event's gap by exactly 1 cycle (the IDLE pop cycle).
- `busy` falls on the cycle the FSM re-enters IDLE with the FIFO empty.

## Structure

- **Package `ps2_pkg`:**
  - Constants `PS2_EXT_PREFIX`=8'hE0, `PS2_BREAK_PREFIX`=8'hF0, `PS2_FRAME_BITS`=11.
  - Event entry typedef `{ext, release, code}`.
  - Odd-parity function.
- **Sub-module `ps2_cmd_fifo`:** synchronous FIFO, width 10, depth `FIFO_DEPTH`, with level output.
- The serialiser FSM and byte sequencer live in the top module.

## Test plan

All scenarios use `HALF_CYCLES`=4, `GAP_SLOTS`=2, `FIFO_DEPTH`=4.

1. **Plain make code:** push code 8'h1D, ext=0, release=0.
   - One frame on `PS2_DAT`, sampled at `PS2_CLK` falls: 0, 1,0,1,1,1,0,0,0, parity 1, stop 1.
   - Start bit at cycle N+2; `busy` high for 104 cycles.
2. **Extended break:** push code 8'h6B, ext=1, release=1.
   - Three frames with bytes E0 (parity 0), F0 (parity 1), 6B (parity 0).
   - Frame starts 104 cycles apart.
3. **Parity extremes:** push 8'h00, then 8'hFF.
   - Both frames carry parity 1.
   - Second start bit exactly 1 cycle after the first gap ends.
4. **Backpressure:**
   - Hold `key_valid` high and push 6 events while the first is transmitting.
   - `key_ready` falls when `fifo_level`=4.
   - No event is lost; all 6 codes are emitted in push order.
5. **Reset mid-frame:**
   - Assert `resetn`=0 during bit 4 of a frame with 3 events queued.
   - `PS2_CLK`/`PS2_DAT` go to 1 with no clock edge needed; `fifo_level`=0.
   - After release, lines stay idle until a new push.
6. **Timing check:**
   - Every `PS2_CLK` low pulse is 4 cycles and every high pulse within a frame is 4 cycles.
   - `PS2_DAT` never changes while `PS2_CLK`=0.
